// File: rtl/alu_serial_seq_if.sv
// Bundle between the core datapath, the bit-serial ALU sequencer and the
// external 1-bit ALU slice.
//
// Handshake: the core raises start for one cycle with op/a_in/b_in valid. The
// sequencer accepts it only while busy is low. It answers with exactly one
// cycle of either done (result and flags valid) or error (illegal op, nothing
// started). There is no back-pressure: done is a pulse and is not acknowledged.
// result/flags hold their values until a later operation completes.
interface alu_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             alu_a;
  logic             alu_b;
  logic             alu_carry_in;
  logic [3:0]       alu_op;
  logic             alu_result;
  logic             alu_carry_out;

  // The environment side: the core issues requests and the slice answers.
  modport master (
    output start, op, a_in, b_in, alu_result, alu_carry_out,
    input  busy, done, error, result, carry_out, overflow, zero,
    input  alu_a, alu_b, alu_carry_in, alu_op
  );

  // The sequencer side.
  modport slave (
    input  start, op, a_in, b_in, alu_result, alu_carry_out,
    output busy, done, error, result, carry_out, overflow, zero,
    output alu_a, alu_b, alu_carry_in, alu_op
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer. It runs a WIDTH-bit ALU operation through an external
// 1-bit ALU slice, LSB first, one bit per clock. The slice carry is chained back.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_serial_seq_if.slave bus,
  output logic          o_dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only the upper WIDTH-1 result bits are stored. The final bit comes straight
  // from the slice on the closing edge.
  logic [WIDTH-1:1] r_res_sh;
  logic [3:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_done;
  logic             r_error;

  logic             w_legal;
  logic             w_accept;
  logic             w_reject;
  logic             w_last;
  logic             w_arith;
  logic [WIDTH-1:0] w_final_res;

  always_comb begin
    w_legal = 1'b0;
    case (bus.op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: w_legal = 1'b1;
      default:                               w_legal = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and control decode
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_legal) begin
            w_accept = 1'b1;
            w_next   = S_RUN;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_last = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_arith     = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_final_res = {bus.alu_result, r_res_sh[WIDTH-1:1]};

  // Datapath: operand shifters, carry chain, result assembly and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res_sh    <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done  <= w_last;
      r_error <= w_reject;
      if (w_accept) begin
        r_a_sh   <= bus.a_in;
        r_b_sh   <= bus.b_in;
        r_op     <= bus.op;
        // SUB is A + ~B + 1. The slice inverts B; the +1 enters as the first carry.
        r_carry  <= (bus.op == OP_SUB);
        r_cnt    <= '0;
        r_res_sh <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sh   <= r_a_sh >> 1;
        r_b_sh   <= r_b_sh >> 1;
        r_res_sh <= w_final_res[WIDTH-1:1];
        r_carry  <= bus.alu_carry_out;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_result    <= w_final_res;
        r_zero      <= (w_final_res == '0);
        r_carry_out <= w_arith & bus.alu_carry_out;
        // r_carry still holds the MSB carry-in during the last bit.
        r_overflow  <= w_arith & (r_carry ^ bus.alu_carry_out);
      end
    end
  end

  assign bus.alu_a        = (r_state == S_RUN) ? r_a_sh[0] : 1'b0;
  assign bus.alu_b        = (r_state == S_RUN) ? r_b_sh[0] : 1'b0;
  assign bus.alu_carry_in = (r_state == S_RUN) ? r_carry   : 1'b0;
  assign bus.alu_op       = (r_state == S_RUN) ? r_op      : 4'b0000;

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;

  assign o_dbg_state = r_state;

endmodule
